mem_block_reader: RTL
=====================

Name: mem_block_reader

Overview:
- Block-read engine for the data memory: given a base address and a word count, it issues sequential reads to Data_mem and streams the returned words out over a valid/ready interface.
- It is the read-side counterpart of the block-write sequences driven into Data_mem: software or the core starts it, and a consumer such as a DMA or debug dump drains it.
- Sits between Data_mem (read port: address in, Data_out back) and any stream consumer.

Parameters:
- ADDR_W, 32, width of the memory address and base address.
- DATA_W, 32, width of the memory word.
- LEN_W, 16, width of the word-count input.
- READ_LATENCY, 1, cycles from Mem_address presented to Mem_data valid (Data_mem is a registered read).
- FIFO_DEPTH, 4, output buffer entries; must be ≥ READ_LATENCY+1 and a power of two.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Start  input  1  one-cycle request pulse; sampled only in IDLE.
- Base_address  input  ADDR_W  first word address; captured on an accepted Start.
- Length  input  LEN_W  number of words to read; captured on an accepted Start.
- Busy  output  1  high from the accepted Start until Done.
- Done  output  1  one-cycle pulse after the last word is accepted downstream.
- Mem_address  output  ADDR_W  read address to Data_mem.
- Mem_we  output  1  tied 0; the block never writes.
- Mem_re  output  1  high in each cycle a read is issued.
- Mem_data  input  DATA_W  Data_mem read data, valid READ_LATENCY cycles after Mem_re.
- Rd_data  output  DATA_W  stream data, driven from the FIFO head.
- Rd_valid  output  1  FIFO is non-empty.
- Rd_ready  input  1  consumer accepts; a transfer occurs when Rd_valid && Rd_ready.

Behaviour:
- Reset (async assert, sync release) sets state=IDLE, Busy=0, Done=0, Mem_re=0, Mem_address=0, Rd_valid=0, Rd_data=0, FIFO empty, all counters 0.
- State machine: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: on Start, capture Base_address and Length. If Length==0, go to DONE. Otherwise go to ISSUE. Busy rises the cycle after Start.
  - ISSUE: a read is issued (Mem_re=1, Mem_address=current address) when credits > 0. Then: address+1, which wraps modulo 2^ADDR_W; remaining-1. After the final issue, go to DRAIN.
  - DRAIN: wait until in-flight count==0 and the FIFO is empty, then go to DONE.
  - DONE: Done=1 for exactly one cycle, Busy=0, then IDLE.
- Credit rule: issue only if (FIFO occupancy + in-flight reads) < FIFO_DEPTH, so returned data never overflows the FIFO. No read is ever dropped or duplicated.
- Return pipeline: a READ_LATENCY-deep valid shift register tracks Mem_re. When the tagged valid emerges, push Mem_data into the FIFO.
- Throughput: 1 word/cycle when Rd_ready is held high. First Rd_valid appears READ_LATENCY+1 cycles after the first Mem_re (memory latency plus FIFO write).
- Simultaneous push and pop on a full or empty FIFO are both legal; occupancy stays unchanged.
- Rd_data and Rd_valid are stable while Rd_valid && !Rd_ready.
- Start while Busy is ignored; the captured values are unchanged.
- Async reset mid-operation aborts immediately. No Done pulse is produced, the FIFO is flushed, and in-flight reads are discarded.

Optional Feature:
- Macro: MEM_BLOCK_READER_CHECKSUM_EN.
- Defined:
  - Adds output port Checksum [DATA_W-1:0], a running modulo-2^DATA_W sum of every word transferred on the stream.
  - Cleared to 0 on an accepted Start and on reset.
  - Holds its final value from Done until the next Start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Preload words 1024..1073 = 32'hFFFFFFFF. Start, Base_address=1024, Length=50, Rd_ready=1 → 50 words of 32'hFFFFFFFF, back-to-back after the initial latency. Mem_address runs 1024..1073, Mem_we is always 0, and Done pulses once.
- Preload word 1024=32'h0000AAAA. Start, Length=1 → single Rd_data=32'h0000AAAA, then Done; Busy was high for the duration.
- Start with Length=0 → no Mem_re and no Rd_valid; Done pulses 2 cycles after Start.
- Length=20 with incrementing preload, Rd_ready toggled randomly and held low for 10 cycles:
  - Mem_re stalls once FIFO_DEPTH words are buffered or in flight.
  - Data stays in order with no loss.
  - Rd_data is held while stalled.
- Base_address=2^ADDR_W-2, Length=4 → Mem_address sequence FFFFFFFE, FFFFFFFF, 0, 1.
- Assert Reset_n low mid-transfer (after 10 of 50 words) → Busy=0, Rd_valid=0, no Done. A new Start afterwards completes normally.
- With MEM_BLOCK_READER_CHECKSUM_EN, 50×32'hFFFFFFFF → Checksum=32'hFFFFFFCE at Done.

Source files
------------

// File: rtl/mem_block_reader.sv
// mem_block_reader: reads a block of consecutive Data_mem words and streams
// them out over a valid/ready interface.
//
// A start request captures a base address and a word count. Reads are issued
// one per cycle while the output buffer has room for the answer. The room
// counted is the buffer occupancy plus the reads still in flight, so returned
// data can never overflow the buffer. Read data comes back READ_LATENCY cycles
// after Mem_re. A valid shift register tracks each read, and the word is
// pushed into a small FIFO when its tag emerges. The stream is driven from
// the FIFO head.
//
// Optional build macro: MEM_BLOCK_READER_CHECKSUM_EN
//   When defined, this adds output Checksum. It is a running modulo-2^DATA_W
//   sum of every word transferred on the stream. It is cleared on an accepted
//   Start and on reset, and it holds its value after Done.
//   When undefined, the port and its logic are absent.

module mem_block_reader #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 16,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_address,
  input  logic [LEN_W-1:0]  Length,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] Mem_address,
  output logic              Mem_we,
  output logic              Mem_re,
  input  logic [DATA_W-1:0] Mem_data,
  output logic [DATA_W-1:0] Rd_data,
  output logic              Rd_valid,
`ifdef MEM_BLOCK_READER_CHECKSUM_EN
  output logic [DATA_W-1:0] Checksum,
`endif
  input  logic              Rd_ready
);

  // FIFO_DEPTH is a power of two, so the pointers wrap naturally.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // The counters must be able to hold the value FIFO_DEPTH itself.
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_remaining;
  logic                r_busy;
  logic                r_done;
  logic                r_mem_re;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [READ_LATENCY-1:0] r_vpipe;
  logic [CNT_W-1:0]    r_inflight;
  logic [CNT_W-1:0]    r_count;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [DATA_W-1:0]   r_fifo_mem [FIFO_DEPTH];

  logic [CNT_W:0]      w_occupied;
  logic                w_credit_ok;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_start_ok;

  // Words already buffered plus words still on their way back from memory.
  assign w_occupied  = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_credit_ok = (w_occupied < DEPTH_C);
  assign w_issue     = (r_state == S_ISSUE) && w_credit_ok;
  assign w_push      = r_vpipe[READ_LATENCY-1];
  assign w_pop       = Rd_valid && Rd_ready;
  assign w_start_ok  = (r_state == S_IDLE) && Start;

  assign Busy        = r_busy;
  assign Done        = r_done;
  assign Mem_re      = r_mem_re;
  assign Mem_address = r_mem_addr;
  assign Mem_we      = 1'b0;
  assign Rd_valid    = (r_count != CNT_ZERO);
  // Gate the head word so the stream reads zero whenever the buffer is empty.
  assign Rd_data     = Rd_valid ? r_fifo_mem[r_rd_ptr] : '0;

  // Control FSM: capture the request, issue reads under credit, wait for drain, pulse Done.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      r_mem_re <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_addr      <= Base_address;
            r_remaining <= Length;
            r_busy      <= 1'b1;
            r_state     <= (Length == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_mem_re    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_addr      <= r_addr + ADDR_ONE;
            r_remaining <= r_remaining - LEN_ONE;
            if (r_remaining == LEN_ONE) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((r_inflight == CNT_ZERO) && (r_count == CNT_ZERO)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Return-path tag pipeline: one bit per cycle of memory latency, following Mem_re.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe[0] <= r_mem_re;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end
    end
  end

  // In-flight read counter: up on an issue decision, down when the word lands in the FIFO.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + CNT_ONE;
        2'b01:   r_inflight <= r_inflight - CNT_ONE;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // FIFO pointers and occupancy. A push and a pop in the same cycle leave occupancy unchanged.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage. It has no reset because the output is gated by occupancy.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= Mem_data;
    end
  end

`ifdef MEM_BLOCK_READER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  assign Checksum = r_checksum;

  // Running sum of delivered words. It restarts on each accepted request.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum + Rd_data;
    end
  end
`else
  // Without the checksum, the start qualifier is only needed by the FSM's own test.
  logic w_unused_start_ok;
  assign w_unused_start_ok = w_start_ok;
`endif

endmodule
